sram_multi_rw: RTL and testbench
================================

Name: sram_multi_rw

Overview:
Parametrised synchronous SRAM with NUM_READ independent read ports and one byte-lane-masked write port. Read latency is configurable. Read-during-write ordering is selectable. Memory is cleared by a hardware sequencer after reset, one word per cycle, instead of a single-cycle clear. Used as a generic register-file/buffer store in datapath blocks that need more than two read ports.

Parameters:
SIZE, 16, number of words (any value >= 2, not necessarily a power of two)
WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH
LANE_WIDTH, 8, bits per write-enable lane; NUM_LANES = WIDTH/LANE_WIDTH
NUM_READ, 3, number of read ports (>= 1)
READ_LAT, 1, read latency in cycles; legal values 1 or 2
BYPASS, 1, 1 = write-first (same-cycle read sees new data); 0 = read-first (read sees old data)
ADDR_WIDTH (localparam), $clog2(SIZE), address width

Ports:
clk  in  1  clock
rstN  in  1  synchronous reset, active low
en  in  1  global access enable; gates issue of new reads/writes only
w  in  1  write request
wAddr  in  ADDR_WIDTH  write address
wBe  in  NUM_LANES  per-lane write enable, bit b covers in[b*LANE_WIDTH +: LANE_WIDTH]
in  in  WIDTH  write data
rEn  in  NUM_READ  per-port read request
rAddr  in  NUM_READ*ADDR_WIDTH  port i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
out  out  NUM_READ*WIDTH  port i data at [i*WIDTH +: WIDTH]
outValid  out  NUM_READ  port i data valid pulse
ready  out  1  high when clear sequence done and accesses accepted
addrErr  out  1  sticky out-of-range access flag

Behaviour:
- Reset: rstN low at a posedge -> state CLEAR, clrCnt=0, ready=0, out=0, outValid=0, addrErr=0, read pipeline flushed. Memory is not written in the reset cycle.
- FSM states CLEAR, READY:
  - CLEAR: each posedge with rstN high writes mem[clrCnt]=0 and increments clrCnt.
  - When clrCnt==SIZE-1 is written, go to READY. ready=1 from the following cycle, i.e. ready rises after exactly SIZE clocks with rstN high.
  - READY: stays until rstN low.
- While ready=0, w, rEn and en are ignored: no memory update, no outValid, addrErr unaffected.
- Issue condition: ready && en.
  - Write: w && wAddr<SIZE -> mem[wAddr] lane b <= in lane b for each wBe[b]=1; other lanes unchanged. wBe=0 is a no-op write.
  - Read port i: rEn[i] -> read issued.
  - en=0: nothing is issued, but the read pipeline keeps advancing.
- Read latency:
  - Issue at edge N -> out[i] updated and outValid[i]=1 after edge N+READ_LAT-1. READ_LAT=1 means registered after the issuing edge.
  - outValid[i] is a single-cycle pulse per issued read.
  - out[i] holds its last value when no read completes.
- Back-to-back reads on any port are allowed every cycle. Ports are fully independent; same address on several ports returns identical data.
- Read-during-write, same cycle, rAddr[i]==wAddr, write issued:
  - BYPASS=1: returned word = new lanes where wBe set, stored lanes elsewhere.
  - BYPASS=0: returned word = pre-write contents.
  - A read issued in a later cycle always sees the write.
- Out-of-range (address >= SIZE, possible only for non-power-of-two SIZE):
  - Write: ignored.
  - Read: returns 0 with normal outValid.
  - Either case sets addrErr=1 on the next cycle. addrErr holds until reset.
- Reset mid-operation: in-flight reads are dropped (no outValid), any write in the reset cycle is discarded, and a full CLEAR re-runs.
- READ_LAT=2: extra register stage holding data and valid per port. Bypass is resolved at issue, not at output.

Test Plan:
- Clear sequence: SIZE=16, release rstN at cycle 0 -> ready=0 for 16 clocks, ready=1 after 16th; read all 16 addresses on port 0 -> all out=0x0000, 16 outValid pulses.
- Byte-lane write: write 0xABCD to addr 5 wBe=11, then 0x1234 to addr 5 wBe=01 -> read addr 5 returns 0xAB34.
- Multi-port concurrency: addr 1=0x1111, 2=0x2222, 3=0x3333; read 1/2/3 on ports 0/1/2 same cycle -> all three outValid together; READ_LAT=2 -> arrive one cycle later than READ_LAT=1.
- Read-during-write: addr 7 holds 0x00FF; write 0xAA55 wBe=11 with port 1 reading addr 7 same cycle -> BYPASS=1 gives 0xAA55, BYPASS=0 gives 0x00FF; next-cycle read gives 0xAA55 for both.
- Gating: en=0 or ready=0 with w=1 and rEn=all-ones -> no memory change, no outValid; a read issued before en fell still completes.
- Reset/out-of-range: SIZE=12, write addr 13 -> ignored, addrErr=1 next cycle; read addr 14 -> out=0; assert rstN=0 with a READ_LAT=2 read in flight -> no outValid, addrErr=0, ready low for 12 clocks.

Source files
------------

// File: rtl/sram_multi_rw.sv
// Multi-read-port synchronous SRAM with a byte-lane-masked write port,
// a post-reset clear sequencer and 1- or 2-cycle registered read latency.
module sram_multi_rw #(
  parameter int SIZE       = 16,
  parameter int WIDTH      = 16,
  parameter int LANE_WIDTH = 8,
  parameter int NUM_READ   = 3,
  parameter int READ_LAT   = 1,
  parameter int BYPASS     = 1,
  localparam int ADDR_WIDTH = $clog2(SIZE),
  localparam int NUM_LANES  = WIDTH / LANE_WIDTH
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           en,
  input  logic                           w,
  input  logic [ADDR_WIDTH-1:0]          wAddr,
  input  logic [NUM_LANES-1:0]           wBe,
  input  logic [WIDTH-1:0]               in,
  input  logic [NUM_READ-1:0]            rEn,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rAddr,
  output logic [NUM_READ*WIDTH-1:0]      out,
  output logic [NUM_READ-1:0]            outValid,
  output logic                           ready,
  output logic                           addrErr
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_WIDTH:0] SIZE_EXT = SIZE[ADDR_WIDTH:0];
  localparam int LAST_I = SIZE - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = LAST_I[ADDR_WIDTH-1:0];

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [WIDTH-1:0]      mem [SIZE];

  logic                  issue;
  logic                  w_ok;
  logic                  wr_go;
  logic                  clr_go;
  logic [WIDTH-1:0]      w_mask;
  logic [ADDR_WIDTH-1:0] r_addr [NUM_READ];
  logic [NUM_READ-1:0]   r_ok;
  logic [NUM_READ-1:0]   rd_go;
  logic [NUM_READ-1:0]   rd_bad;
  logic [WIDTH-1:0]      rd_word [NUM_READ];
  logic [WIDTH-1:0]      fin_data [NUM_READ];
  logic [NUM_READ-1:0]   fin_valid;

  // ready is low during the reset cycle's predecessor state only via rstN gating
  assign issue  = rstN && ready && en;
  assign w_ok   = ({1'b0, wAddr} < SIZE_EXT);
  assign wr_go  = issue && w && w_ok;
  assign clr_go = rstN && (state == CLEAR);

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < NUM_LANES; b++) begin
      w_mask[b*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wBe[b]}};
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      r_addr[i] = rAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      r_ok[i]   = ({1'b0, r_addr[i]} < SIZE_EXT);
    end
  end

  // Bypass merges the incoming lanes at issue time so latency stages carry final data
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_go[i]   = issue && rEn[i];
      rd_bad[i]  = rd_go[i] && !r_ok[i];
      rd_word[i] = '0;
      if (r_ok[i]) begin
        rd_word[i] = mem[r_addr[i]];
        if (BYPASS != 0 && wr_go && r_addr[i] == wAddr) begin
          rd_word[i] = (in & w_mask) | (mem[r_addr[i]] & ~w_mask);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_go) begin
      mem[clr_cnt] <= '0;
    end else if (wr_go) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (wBe[b]) mem[wAddr][b*LANE_WIDTH +: LANE_WIDTH] <= in[b*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0]    s1_data [NUM_READ];
      logic [NUM_READ-1:0] s1_valid;

      always_ff @(posedge clk) begin
        if (!rstN) begin
          s1_valid <= '0;
          for (int i = 0; i < NUM_READ; i++) s1_data[i] <= '0;
        end else begin
          s1_valid <= rd_go;
          for (int i = 0; i < NUM_READ; i++) s1_data[i] <= rd_word[i];
        end
      end

      always_comb begin
        fin_valid = s1_valid;
        for (int i = 0; i < NUM_READ; i++) fin_data[i] = s1_data[i];
      end
    end else begin : g_lat1
      always_comb begin
        fin_valid = rd_go;
        for (int i = 0; i < NUM_READ; i++) fin_data[i] = rd_word[i];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      ready    <= 1'b0;
      addrErr  <= 1'b0;
      out      <= '0;
      outValid <= '0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state <= READY;
          ready <= 1'b1;
        end
      end
      if (issue && ((w && !w_ok) || (|rd_bad))) addrErr <= 1'b1;
      outValid <= fin_valid;
      for (int i = 0; i < NUM_READ; i++) begin
        if (fin_valid[i]) out[i*WIDTH +: WIDTH] <= fin_data[i];
      end
    end
  end

endmodule

// File: tb/tb_sram_multi_rw.sv
// Directed self-checking bench for sram_multi_rw: three instances cover
// write-first/latency 1, read-first/latency 2 and a non-power-of-two size.
module tb_sram_multi_rw;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en_ab;
  logic        en_c;
  logic        w;
  logic [3:0]  w_addr;
  logic [1:0]  w_be;
  logic [15:0] din;
  logic [2:0]  r_en;
  logic [11:0] r_addr;

  logic [47:0] out_a, out_b, out_c;
  logic [2:0]  vld_a, vld_b, vld_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        err_a, err_b, err_c;

  int checks = 0;
  int fails  = 0;
  int cnt_b  = 0;

  always #5 clk = ~clk;

  sram_multi_rw #(.SIZE(16), .WIDTH(16), .LANE_WIDTH(8), .NUM_READ(3), .READ_LAT(1), .BYPASS(1)) dut_a (
    .clk(clk), .rstN(rstN), .en(en_ab), .w(w), .wAddr(w_addr), .wBe(w_be), .in(din),
    .rEn(r_en), .rAddr(r_addr), .out(out_a), .outValid(vld_a), .ready(rdy_a), .addrErr(err_a));

  sram_multi_rw #(.SIZE(16), .WIDTH(16), .LANE_WIDTH(8), .NUM_READ(3), .READ_LAT(2), .BYPASS(0)) dut_b (
    .clk(clk), .rstN(rstN), .en(en_ab), .w(w), .wAddr(w_addr), .wBe(w_be), .in(din),
    .rEn(r_en), .rAddr(r_addr), .out(out_b), .outValid(vld_b), .ready(rdy_b), .addrErr(err_b));

  sram_multi_rw #(.SIZE(12), .WIDTH(16), .LANE_WIDTH(8), .NUM_READ(3), .READ_LAT(2), .BYPASS(1)) dut_c (
    .clk(clk), .rstN(rstN), .en(en_c), .w(w), .wAddr(w_addr), .wBe(w_be), .in(din),
    .rEn(r_en), .rAddr(r_addr), .out(out_c), .outValid(vld_c), .ready(rdy_c), .addrErr(err_c));

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wi, input logic [3:0] wa, input logic [1:0] be,
                               input logic [15:0] d, input logic [2:0] re, input logic [11:0] ra);
    w = wi; w_addr = wa; w_be = be; din = d; r_en = re; r_addr = ra;
    tick();
    w = 1'b0; r_en = 3'b000;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; en_ab = 1'b0; en_c = 1'b0; w = 1'b0; w_addr = '0; w_be = '0;
    din = '0; r_en = '0; r_addr = '0;
    tick(); tick();
    checkOutput("rst_ready_a", rdy_a, 0);
    checkOutput("rst_valid_a", vld_a, 0);
    checkOutput("rst_err_a",   err_a, 0);
    checkOutput("rst_out_a",   out_a, 0);
    checkOutput("rst_valid_b", vld_b, 0);
    checkOutput("rst_out_b",   out_b, 0);
    checkOutput("rst_ready_c", rdy_c, 0);

    // clear sequence with writes/reads requested while not ready
    rstN = 1'b1; en_ab = 1'b1; w = 1'b1; w_addr = 4'd3; w_be = 2'b11; din = 16'hFFFF;
    r_en = 3'b111; r_addr = {4'd3, 4'd3, 4'd3};
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput($sformatf("clr_ready_a_%0d", k), rdy_a, (k >= 16));
      checkOutput($sformatf("clr_ready_b_%0d", k), rdy_b, (k >= 16));
      checkOutput($sformatf("clr_ready_c_%0d", k), rdy_c, (k >= 12));
      checkOutput($sformatf("clr_valid_a_%0d", k), vld_a, 0);
      checkOutput($sformatf("clr_valid_b_%0d", k), vld_b, 0);
    end
    w = 1'b0; r_en = 3'b000;
    checkOutput("clr_err_a", err_a, 0);

    for (int a = 0; a < 16; a++) begin
      r_en = 3'b001; r_addr = {8'd0, 4'(a)};
      tick();
      checkOutput($sformatf("zero_valid_a_%0d", a), vld_a, 3'b001);
      checkOutput($sformatf("zero_data_a_%0d", a), out_a[15:0], 16'h0000);
      checkOutput($sformatf("zero_valid_b_%0d", a), vld_b[0], (a >= 1));
      checkOutput($sformatf("zero_data_b_%0d", a), out_b[15:0], 16'h0000);
      if (vld_b[0]) cnt_b++;
    end
    r_en = 3'b000;
    tick();
    if (vld_b[0]) cnt_b++;
    checkOutput("zero_pulse_end_a", vld_a, 0);
    checkOutput("zero_pulse_count_b", cnt_b, 16);

    // byte-lane write merge
    applyStimulus(1, 4'd5, 2'b11, 16'hABCD, 3'b000, 12'd0);
    applyStimulus(1, 4'd5, 2'b01, 16'h1234, 3'b000, 12'd0);
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b001, {8'd0, 4'd5});
    checkOutput("lane_valid_a", vld_a, 3'b001);
    checkOutput("lane_data_a", out_a[15:0], 16'hAB34);
    tick();
    checkOutput("lane_valid_b", vld_b, 3'b001);
    checkOutput("lane_data_b", out_b[15:0], 16'hAB34);

    // three ports in the same cycle
    applyStimulus(1, 4'd1, 2'b11, 16'h1111, 3'b000, 12'd0);
    applyStimulus(1, 4'd2, 2'b11, 16'h2222, 3'b000, 12'd0);
    applyStimulus(1, 4'd3, 2'b11, 16'h3333, 3'b000, 12'd0);
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b111, {4'd3, 4'd2, 4'd1});
    checkOutput("mp_valid_a", vld_a, 3'b111);
    checkOutput("mp_data_a", out_a, 48'h3333_2222_1111);
    checkOutput("mp_early_b", vld_b, 3'b000);
    tick();
    checkOutput("mp_pulse_a", vld_a, 3'b000);
    checkOutput("mp_hold_a", out_a, 48'h3333_2222_1111);
    checkOutput("mp_valid_b", vld_b, 3'b111);
    checkOutput("mp_data_b", out_b, 48'h3333_2222_1111);

    // read during write on port 1
    applyStimulus(1, 4'd7, 2'b11, 16'h00FF, 3'b000, 12'd0);
    applyStimulus(1, 4'd7, 2'b11, 16'hAA55, 3'b010, {4'd0, 4'd7, 4'd0});
    checkOutput("rdw_valid_a", vld_a, 3'b010);
    checkOutput("rdw_new_a", out_a[31:16], 16'hAA55);
    tick();
    checkOutput("rdw_valid_b", vld_b, 3'b010);
    checkOutput("rdw_old_b", out_b[31:16], 16'h00FF);
    applyStimulus(1, 4'd7, 2'b01, 16'h1166, 3'b010, {4'd0, 4'd7, 4'd0});
    checkOutput("rdw_lane_a", out_a[31:16], 16'hAA66);
    checkOutput("rdw_hold_p0_a", out_a[15:0], 16'h1111);
    tick();
    checkOutput("rdw_lane_old_b", out_b[31:16], 16'hAA55);
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b010, {4'd0, 4'd7, 4'd0});
    checkOutput("rdw_next_a", out_a[31:16], 16'hAA66);
    tick();
    checkOutput("rdw_next_b", out_b[31:16], 16'hAA66);

    // en gating while a latency-2 read is still in flight
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b001, {8'd0, 4'd5});
    checkOutput("gate_pre_a", out_a[15:0], 16'hAB34);
    en_ab = 1'b0;
    applyStimulus(1, 4'd9, 2'b11, 16'hFFFF, 3'b111, {4'd9, 4'd9, 4'd9});
    checkOutput("gate_valid_a", vld_a, 3'b000);
    checkOutput("gate_inflight_b", vld_b, 3'b001);
    checkOutput("gate_inflight_data_b", out_b[15:0], 16'hAB34);
    en_ab = 1'b1;
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b001, {8'd0, 4'd9});
    checkOutput("gate_mem_a", out_a[15:0], 16'h0000);
    checkOutput("gate_noissue_b", vld_b, 3'b000);
    tick();
    checkOutput("gate_mem_b", out_b[15:0], 16'h0000);
    checkOutput("gate_err_a", err_a, 0);

    // out-of-range on the 12-word instance
    en_ab = 1'b0; en_c = 1'b1;
    applyStimulus(1, 4'd4, 2'b11, 16'h5A5A, 3'b000, 12'd0);
    checkOutput("oor_err_pre_c", err_c, 0);
    applyStimulus(1, 4'd13, 2'b11, 16'hFFFF, 3'b000, 12'd0);
    checkOutput("oor_err_c", err_c, 1);
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b100, {4'd4, 8'd0});
    tick();
    checkOutput("oor_pre_valid_c", vld_c, 3'b100);
    checkOutput("oor_pre_data_c", out_c[47:32], 16'h5A5A);
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b101, {4'd14, 4'd0, 4'd1});
    tick();
    checkOutput("oor_valid_c", vld_c, 3'b101);
    checkOutput("oor_data_c", out_c[47:32], 16'h0000);
    checkOutput("oor_addr1_c", out_c[15:0], 16'h0000);
    checkOutput("oor_sticky_c", err_c, 1);

    // reset with a read in flight and a write in the reset cycle
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b001, {8'd0, 4'd4});
    rstN = 1'b0; w = 1'b1; w_addr = 4'd4; w_be = 2'b11; din = 16'h7777;
    tick();
    w = 1'b0;
    checkOutput("mid_rst_valid_c", vld_c, 3'b000);
    checkOutput("mid_rst_err_c", err_c, 0);
    checkOutput("mid_rst_ready_c", rdy_c, 0);
    checkOutput("mid_rst_out_c", out_c, 48'h0);
    rstN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("reclr_ready_c_%0d", k), rdy_c, (k >= 12));
      checkOutput($sformatf("reclr_valid_c_%0d", k), vld_c, 0);
    end
    applyStimulus(0, 4'd0, 2'b00, 16'h0000, 3'b001, {8'd0, 4'd4});
    tick();
    checkOutput("reclr_read_valid_c", vld_c, 3'b001);
    checkOutput("reclr_read_data_c", out_c[15:0], 16'h0000);
    checkOutput("reclr_err_c", err_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
